// File: rtl/ps_frame_pkg.sv
// Shared frame constants and parser state type for the power-supply trigger link.
// Imported by both the receive parser and the transmit-side frame builder.
package ps_frame_pkg;

    localparam logic [7:0] K_SOP       = 8'h3C;
    localparam logic [7:0] K_EOP       = 8'hBC;
    localparam logic [7:0] CMD_TRIGGER = 8'h70;
    localparam logic [7:0] CMD_STATUS  = 8'h40;
    localparam int         FRAME_LEN   = 10;

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        EOP_WAIT
    } frame_state_e;

    function automatic logic is_command(input logic [7:0] b);
        return (b == CMD_TRIGGER) || (b == CMD_STATUS);
    endfunction

endpackage

// File: rtl/ps_frame_rx_if.sv
// Byte-stream input and strobe/counter output bundle of the frame parser.
// master = decoder/consumer side, slave = the parser itself.
interface ps_frame_rx_if #(
    parameter int CNT_W = 16
);
    logic             rx_valid;
    logic [7:0]       rx_data;
    logic             rx_is_k;
    logic             rx_code_err;
    logic             trig_pulse;
    logic             status_pulse;
    logic             frame_err;
    logic [CNT_W-1:0] good_count;
    logic [CNT_W-1:0] err_count;
    logic             in_frame;

    modport master (
        output rx_valid, rx_data, rx_is_k, rx_code_err,
        input  trig_pulse, status_pulse, frame_err, good_count, err_count, in_frame
    );

    modport slave (
        input  rx_valid, rx_data, rx_is_k, rx_code_err,
        output trig_pulse, status_pulse, frame_err, good_count, err_count, in_frame
    );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);
    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (inc_i && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count_o = count_q;
endmodule

// File: rtl/ps_frame_rx.sv
// Receive-side parser for the 10-byte SOP/payload/EOP trigger frame; emits one
// registered strobe per good or bad frame and keeps saturating frame counters.
module ps_frame_rx
    import ps_frame_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    ps_frame_rx_if.slave bus
);
    localparam int GAP_W = $clog2(TIMEOUT + 1);

    frame_state_e     state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic             trig_cmd_q, trig_cmd_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             trig_q, status_q, err_q, in_frame_q;
    logic             trig_d, status_d, err_d;
    logic             is_sop, byte_bad;
    logic [CNT_W-1:0] good_cnt, err_cnt;

    // A byte carrying a code error never counts as a usable SOP, so it is
    // dropped in IDLE and cannot resync an errored frame.
    always_comb begin
        is_sop     = bus.rx_valid && bus.rx_is_k && (bus.rx_data == K_SOP) && !bus.rx_code_err;
        byte_bad   = 1'b0;
        state_d    = state_q;
        idx_d      = idx_q;
        trig_cmd_d = trig_cmd_q;
        gap_d      = gap_q;
        trig_d     = 1'b0;
        status_d   = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_sop) begin
                    state_d = PAYLOAD;
                    idx_d   = 4'd1;
                    gap_d   = '0;
                end
            end
            PAYLOAD, EOP_WAIT: begin
                if (bus.rx_valid) begin
                    gap_d = '0;
                    if (bus.rx_code_err)        byte_bad = 1'b1;
                    else if (state_q == EOP_WAIT) byte_bad = !(bus.rx_is_k && (bus.rx_data == K_EOP));
                    else if (bus.rx_is_k)       byte_bad = 1'b1;
                    else if (idx_q == 4'd2)     byte_bad = !is_command(bus.rx_data);
                    else                        byte_bad = (bus.rx_data != 8'h00);

                    if (byte_bad) begin
                        err_d   = 1'b1;
                        state_d = is_sop ? PAYLOAD : IDLE;
                        idx_d   = is_sop ? 4'd1 : 4'd0;
                    end else if (state_q == EOP_WAIT) begin
                        trig_d   = trig_cmd_q;
                        status_d = !trig_cmd_q;
                        state_d  = IDLE;
                        idx_d    = 4'd0;
                    end else begin
                        if (idx_q == 4'd2) trig_cmd_d = (bus.rx_data == CMD_TRIGGER);
                        idx_d = idx_q + 4'd1;
                        if (idx_q == 4'(FRAME_LEN - 2)) state_d = EOP_WAIT;
                    end
                end else if (gap_q == GAP_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                    idx_d   = 4'd0;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            trig_cmd_q <= 1'b0;
            gap_q      <= '0;
            trig_q     <= 1'b0;
            status_q   <= 1'b0;
            err_q      <= 1'b0;
            in_frame_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            trig_cmd_q <= trig_cmd_d;
            gap_q      <= gap_d;
            trig_q     <= trig_d;
            status_q   <= status_d;
            err_q      <= err_d;
            in_frame_q <= (state_d != IDLE);
        end
    end

    // Counters take the next-state strobes so they change alongside the strobe outputs.
    sat_counter #(.WIDTH(CNT_W)) u_good_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (trig_d | status_d),
        .count_o (good_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_err_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (err_d),
        .count_o (err_cnt)
    );

    assign bus.trig_pulse   = trig_q;
    assign bus.status_pulse = status_q;
    assign bus.frame_err    = err_q;
    assign bus.in_frame     = in_frame_q;
    assign bus.good_count   = good_cnt;
    assign bus.err_count    = err_cnt;
endmodule

// File: tb/tb_ps_frame_rx.sv
// Randomised and directed bench for ps_frame_rx against a frame-level reference model.
module tb_ps_frame_rx;
    localparam int TIMEOUT = 16;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    ps_frame_rx_if #(.CNT_W(16)) bus ();
    ps_frame_rx_if #(.CNT_W(4))  bus4 ();

    assign bus4.rx_valid    = bus.rx_valid;
    assign bus4.rx_data     = bus.rx_data;
    assign bus4.rx_is_k     = bus.rx_is_k;
    assign bus4.rx_code_err = bus.rx_code_err;

    ps_frame_rx #(.TIMEOUT(TIMEOUT), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    ps_frame_rx #(.TIMEOUT(TIMEOUT), .CNT_W(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: bytes of the frame received so far; empty means not in a frame.
    logic [7:0] frame_q[$];
    int         gap;
    int         n_good;
    int         n_err;
    bit         exp_trig, exp_stat, exp_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic int sat(input int n, input int maxv);
        return (n > maxv) ? maxv : n;
    endfunction

    task automatic model_reset();
        frame_q.delete();
        gap = 0; n_good = 0; n_err = 0;
        exp_trig = 0; exp_stat = 0; exp_err = 0;
    endtask

    task automatic model_step(input bit v, input logic [7:0] d, input bit k, input bit ce);
        bit sop;
        bit ok;
        int p;
        sop = v && k && (d == 8'h3C) && !ce;
        exp_trig = 0; exp_stat = 0; exp_err = 0;
        if (frame_q.size() == 0) begin
            if (sop) begin
                frame_q.push_back(d);
                gap = 0;
            end
        end else if (!v) begin
            gap++;
            if (gap == TIMEOUT) begin
                exp_err = 1;
                frame_q.delete();
            end
        end else begin
            gap = 0;
            p = frame_q.size();
            ok = !ce && (k == (p == 9)) &&
                 ((p == 2) ? (d == 8'h70 || d == 8'h40) : (p == 9) ? (d == 8'hBC) : (d == 8'h00));
            if (!ok) begin
                exp_err = 1;
                frame_q.delete();
                if (sop) frame_q.push_back(d);
            end else if (p == 9) begin
                if (frame_q[2] == 8'h70) exp_trig = 1;
                else exp_stat = 1;
                frame_q.delete();
            end else begin
                frame_q.push_back(d);
            end
        end
        if (exp_err) n_err++;
        if (exp_trig || exp_stat) n_good++;
    endtask

    task automatic compare_all();
        chk("trig_pulse",   32'(bus.trig_pulse),   32'(exp_trig));
        chk("status_pulse", 32'(bus.status_pulse), 32'(exp_stat));
        chk("frame_err",    32'(bus.frame_err),    32'(exp_err));
        chk("in_frame",     32'(bus.in_frame),     32'(frame_q.size() > 0));
        chk("good_count",   32'(bus.good_count),   32'(sat(n_good, 65535)));
        chk("err_count",    32'(bus.err_count),    32'(sat(n_err, 65535)));
        chk("good_count4",  32'(bus4.good_count),  32'(sat(n_good, 15)));
        chk("err_count4",   32'(bus4.err_count),   32'(sat(n_err, 15)));
    endtask

    task automatic drive(input bit v, input logic [7:0] d, input bit k, input bit ce);
        @(negedge clk);
        bus.rx_valid = v; bus.rx_data = d; bus.rx_is_k = k; bus.rx_code_err = ce;
        @(posedge clk);
        model_step(v, d, k, ce);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'($urandom), 1'($urandom), 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.rx_valid = 0; bus.rx_data = 0; bus.rx_is_k = 0; bus.rx_code_err = 0;
        model_reset();
        #1;
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // bad_idx/cerr_idx >= 10 mean no corruption; gap_len idle cycles precede byte gap_at.
    task automatic send_frame(input logic [7:0] cmd, input int bad_idx, input logic [7:0] bad_val,
                              input bit flip_k, input int cerr_idx, input bit toggle,
                              input int gap_at, input int gap_len);
        logic [7:0] d;
        bit         k;
        for (int i = 0; i < 10; i++) begin
            d = (i == 0) ? 8'h3C : (i == 9) ? 8'hBC : (i == 2) ? cmd : 8'h00;
            k = (i == 0) || (i == 9);
            if (i == bad_idx) begin
                d = bad_val;
                k = k ^ flip_k;
            end
            if (toggle && i != 0) idle(1);
            if (i == gap_at) idle(gap_len);
            drive(1'b1, d, k, i == cerr_idx);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] cmd;
        logic [7:0] fd;
        int         r;
        checks = 0; errors = 0;
        rst_n = 1'b0;
        bus.rx_valid = 0; bus.rx_data = 0; bus.rx_is_k = 0; bus.rx_code_err = 0;
        model_reset();
        #12;
        do_reset();
        chk("rst_good", 32'(bus.good_count), 32'd0);
        chk("rst_inframe", 32'(bus.in_frame), 32'd0);
        idle(2);

        // Good trigger frame
        send_frame(8'h70, 99, 8'h00, 0, 99, 0, 99, 0);
        chk("t1_trig", 32'(bus.trig_pulse), 32'd1);
        chk("t1_good", 32'(bus.good_count), 32'd1);
        chk("t1_err", 32'(bus.frame_err), 32'd0);
        idle(1);
        chk("t1_trig_one_cycle", 32'(bus.trig_pulse), 32'd0);
        idle(2);

        // Status frame with rx_valid toggling
        send_frame(8'h40, 99, 8'h00, 0, 99, 1, 99, 0);
        chk("t2_status", 32'(bus.status_pulse), 32'd1);
        chk("t2_no_trig", 32'(bus.trig_pulse), 32'd0);
        chk("t2_good", 32'(bus.good_count), 32'd2);
        idle(2);

        // Corrupt byte 5: error flagged right after byte 5, rest ignored
        for (int i = 0; i < 6; i++)
            drive(1'b1, (i == 0) ? 8'h3C : (i == 2) ? 8'h70 : (i == 5) ? 8'h01 : 8'h00, i == 0, 1'b0);
        chk("t3_err", 32'(bus.frame_err), 32'd1);
        chk("t3_errcnt", 32'(bus.err_count), 32'd1);
        chk("t3_inframe", 32'(bus.in_frame), 32'd0);
        for (int i = 6; i < 10; i++) drive(1'b1, (i == 9) ? 8'hBC : 8'h00, i == 9, 1'b0);
        chk("t3_no_trig", 32'(bus.trig_pulse), 32'd0);
        chk("t3_good", 32'(bus.good_count), 32'd2);
        idle(2);

        // SOP at idx 4 resyncs into the following good frame
        drive(1'b1, 8'h3C, 1'b1, 1'b0);
        drive(1'b1, 8'h00, 1'b0, 1'b0);
        drive(1'b1, 8'h70, 1'b0, 1'b0);
        drive(1'b1, 8'h00, 1'b0, 1'b0);
        send_frame(8'h70, 99, 8'h00, 0, 99, 0, 99, 0);
        chk("t4_trig", 32'(bus.trig_pulse), 32'd1);
        chk("t4_err", 32'(bus.err_count), 32'd2);
        chk("t4_good", 32'(bus.good_count), 32'd3);
        idle(2);

        // Gap of TIMEOUT-1 is tolerated; a gap of TIMEOUT at idx 3 aborts
        send_frame(8'h40, 99, 8'h00, 0, 99, 0, 5, TIMEOUT - 1);
        chk("t5_gap_ok", 32'(bus.good_count), 32'd4);
        drive(1'b1, 8'h3C, 1'b1, 1'b0);
        drive(1'b1, 8'h00, 1'b0, 1'b0);
        drive(1'b1, 8'h70, 1'b0, 1'b0);
        idle(TIMEOUT);
        chk("t5_timeout_err", 32'(bus.frame_err), 32'd1);
        chk("t5_timeout_inframe", 32'(bus.in_frame), 32'd0);
        chk("t5_errcnt", 32'(bus.err_count), 32'd3);
        idle(2);

        // Back-to-back frames, no dead cycle
        send_frame(8'h70, 99, 8'h00, 0, 99, 0, 99, 0);
        send_frame(8'h40, 99, 8'h00, 0, 99, 0, 99, 0);
        chk("t6_b2b_status", 32'(bus.status_pulse), 32'd1);
        chk("t6_b2b_good", 32'(bus.good_count), 32'd6);

        // Reset mid-frame discards the partial frame
        for (int i = 0; i < 5; i++) drive(1'b1, (i == 0) ? 8'h3C : (i == 2) ? 8'h70 : 8'h00, i == 0, 1'b0);
        do_reset();
        chk("t7_rst_good", 32'(bus.good_count), 32'd0);
        chk("t7_rst_err", 32'(bus.err_count), 32'd0);
        for (int i = 5; i < 10; i++) drive(1'b1, (i == 9) ? 8'hBC : 8'h00, i == 9, 1'b0);
        chk("t7_no_strobe", 32'(bus.trig_pulse), 32'd0);
        chk("t7_still_zero", 32'(bus.good_count), 32'd0);

        // 2^4+3 bad frames saturate the 4-bit error counter
        for (int f = 0; f < 19; f++) begin
            drive(1'b1, 8'h3C, 1'b1, 1'b0);
            drive(1'b1, 8'h01, 1'b0, 1'b0);
        end
        chk("t8_sat4", 32'(bus4.err_count), 32'hF);
        chk("t8_cnt16", 32'(bus.err_count), 32'd19);
        idle(2);

        // Randomised frames, corruption, code errors, gaps and filler
        for (int f = 0; f < 300; f++) begin
            r = int'($urandom_range(0, 9));
            cmd = (r == 0) ? 8'($urandom) : (r < 5) ? 8'h70 : 8'h40;
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
                fd = 8'($urandom);
                drive(1'b1, fd, (fd == 8'h3C) ? 1'b0 : 1'($urandom), 1'b0);
            end
            send_frame(cmd, int'($urandom_range(0, 29)), 8'($urandom), 1'($urandom),
                       int'($urandom_range(0, 60)), 1'($urandom_range(0, 3) == 0),
                       int'($urandom_range(1, 9)),
                       ($urandom_range(0, 9) == 0) ? int'($urandom_range(TIMEOUT - 2, TIMEOUT + 1))
                                                   : int'($urandom_range(0, 3)));
        end
        idle(TIMEOUT + 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ps_frame_rx.md
# ps_frame_rx

Receive-side frame parser for the power-supply trigger link: consumes the decoded 8b/10b byte stream, recognises the 10-byte frame (SOP, 8 payload bytes, EOP), validates it, and emits a single-cycle trigger or status strobe per good frame. Sits between the link's 8b/10b decoder and the trigger distribution logic. It mirrors the transmit-side frame builder.

## Interface
- TIMEOUT, default 64: max clk cycles between accepted bytes inside a frame before abort (≥2).
- CNT_W, default 16: width of the saturating frame and error counters.
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx_valid  in  1  byte strobe from the decoder
- rx_data  in  8  decoded byte
- rx_is_k  in  1  rx_data is a K character
- rx_code_err  in  1  decoder disparity/code error on this byte
- trig_pulse  out  1  one-cycle strobe for a good trigger frame
- status_pulse  out  1  one-cycle strobe for a good non-trigger (status) frame
- frame_err  out  1  one-cycle strobe for any aborted or invalid frame
- good_count  out  CNT_W  saturating count of good frames
- err_count  out  CNT_W  saturating count of frame errors
- in_frame  out  1  high while the parser is inside a frame

## Operation
- Frame, byte index 0..9: 0 = SOP (K, 0x3C, K28.1); 1 = 0x00; 2 = command, 0x70 trigger or 0x40 status; 3..8 = 0x00; 9 = EOP (K, 0xBC, K28.5). Payload bytes 1..8 must have rx_is_k=0.
- States: IDLE, PAYLOAD, EOP_WAIT.
- IDLE: SOP accepted → PAYLOAD, idx=1. Any other byte ignored silently (no error, inter-frame filler).
- PAYLOAD: each accepted byte checked against expected value; command latched at idx 2; idx increments; after idx 8 → EOP_WAIT.
- EOP_WAIT: EOP → frame good; strobe per latched command; → IDLE.
- Error conditions (any state but IDLE): rx_code_err; wrong value; K char in payload; non-EOP at idx 9; command not 0x70/0x40; gap timeout. Action: frame_err strobe, err_count++, return to IDLE — except that an SOP causing the error restarts directly into PAYLOAD idx=1 (resync).
- An error within a frame is flagged immediately (on the offending byte), not deferred to EOP; at most one frame_err per frame.
- rx_code_err in IDLE: ignored.
- Gap timer: cleared on every accepted byte; counts while in PAYLOAD/EOP_WAIT with rx_valid=0; reaching TIMEOUT → error, IDLE.
- Counters saturate at all-ones; never wrap.

## Timing
- Reset values: all strobes 0, in_frame 0, counters 0, state IDLE, idx 0, gap timer 0.
- Outputs registered: trig_pulse/status_pulse/frame_err assert the cycle after the deciding byte is accepted, for exactly one cycle; counters update in the same cycle as the strobe.
- Back-to-back frames (EOP then SOP on the next valid cycle) both accepted; no dead cycle needed.
- in_frame rises the cycle after SOP accepted, falls the cycle after EOP or error.
- Reset mid-frame: everything returns to reset values immediately; partial frame discarded with no strobe and no count.

## Structure
- Shared package ps_frame_pkg: K_SOP=8'h3C, K_EOP=8'hBC, CMD_TRIGGER=8'h70, CMD_STATUS=8'h40, FRAME_LEN=10, state enum; also used by the transmit-side builder.
- One sub-module: sat_counter (parameterised width, inc input, saturating), instanced for good_count and err_count.
- Expected size ~200 lines.

## Test plan
- Good trigger frame 3C(K),00,70,00×6... i.e. 00,70,00,00,00,00,00,00,BC(K) → one trig_pulse one cycle after EOP, good_count=1, no frame_err.
- Good status frame with cmd 0x40, rx_valid toggling every other cycle → one status_pulse, no trigger.
- Corrupt byte 5 = 0x01 → frame_err the cycle after byte 5, err_count=1, following EOP ignored, no strobe.
- SOP at idx 4 then a complete good frame → one frame_err, then one trig_pulse (resync).
- rx_valid held low TIMEOUT cycles at idx 3 → frame_err, in_frame low; rst_n pulse mid-frame → no strobe, counters 0.
- 2^CNT_W+3 bad frames (CNT_W reduced to 4) → err_count stays 4'hF.
